// File: rtl/seven_seg_decoder.sv
// Recovers the hex nibble from sampled 7-segment lines, with a stability filter.
// Optional saturating invalid-pattern counter enabled by SEG_ERR_CNT_EN.
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Invalid,
  output logic       o_Blank
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [7:0] o_Err_Count
`endif
);

  localparam logic [15:0] LastCount = 16'(STABLE_CYCLES - 1);

  logic [6:0]  segIn;
  logic [6:0]  sync1_q, sync2_q;
  logic [6:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  last_q, last_d;
  logic [3:0]  num_q, num_d;
  logic        valid_q, valid_d;
  logic        invalid_q, invalid_d;
  logic        blank_q, blank_d;
  logic [4:0]  decoded;

  assign segIn = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                  i_Segment_E, i_Segment_F, i_Segment_G};

  // Returns {hit, nibble}; hit is low for anything that is not a hex glyph.
  function automatic logic [4:0] decodeSeg(input logic [6:0] p);
    case (p)
      7'h7E:   decodeSeg = 5'h10;
      7'h30:   decodeSeg = 5'h11;
      7'h6D:   decodeSeg = 5'h12;
      7'h79:   decodeSeg = 5'h13;
      7'h33:   decodeSeg = 5'h14;
      7'h5B:   decodeSeg = 5'h15;
      7'h5F:   decodeSeg = 5'h16;
      7'h70:   decodeSeg = 5'h17;
      7'h7F:   decodeSeg = 5'h18;
      7'h7B:   decodeSeg = 5'h19;
      7'h77:   decodeSeg = 5'h1A;
      7'h1F:   decodeSeg = 5'h1B;
      7'h4E:   decodeSeg = 5'h1C;
      7'h3D:   decodeSeg = 5'h1D;
      7'h4F:   decodeSeg = 5'h1E;
      7'h47:   decodeSeg = 5'h1F;
      default: decodeSeg = 5'h00;
    endcase
  endfunction

  assign decoded = decodeSeg(cand_q);

  // The counter parks at its last value once stable, so a held pattern is accepted once.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    num_d     = num_q;
    valid_d   = 1'b0;
    invalid_d = 1'b0;
    blank_d   = blank_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < LastCount) begin
      cnt_d = cnt_q + 16'd1;
    end else if (cand_q != last_q) begin
      last_d = cand_q;
      if (cand_q == 7'h00) begin
        blank_d = 1'b1;
      end else if (decoded[4]) begin
        num_d   = decoded[3:0];
        valid_d = 1'b1;
        blank_d = 1'b0;
      end else begin
        invalid_d = 1'b1;
        blank_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      num_q     <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      blank_q   <= 1'b1;
    end else begin
      sync1_q   <= segIn;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      blank_q   <= blank_d;
    end
  end

  assign o_Binary_Num = num_q;
  assign o_Valid      = valid_q;
  assign o_Invalid    = invalid_q;
  assign o_Blank      = blank_q;

`ifdef SEG_ERR_CNT_EN
  logic [7:0] errCnt_q, errCnt_d;

  assign errCnt_d = (invalid_d && errCnt_q != 8'hFF) ? errCnt_q + 8'd1 : errCnt_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) errCnt_q <= '0;
    else          errCnt_q <= errCnt_d;
  end

  assign o_Err_Count = errCnt_q;
`endif

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed-vector bench for seven_seg_decoder with STABLE_CYCLES = 16.
// Error-counter checks run only when SEG_ERR_CNT_EN is defined.
module tb_seven_seg_decoder;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [6:0] seg = 7'h00;
  logic [3:0] binaryNum;
  logic       valid, invalid, blank;
`ifdef SEG_ERR_CNT_EN
  logic [7:0] errCount;
`endif

  int total = 0;
  int bad = 0;
  int validCount, invalidCount, firstValidEdge, lastNum;

  seven_seg_decoder #(.STABLE_CYCLES(16)) dut (
    .i_Clk(clk),
    .i_Rst_L(rstN),
    .i_Segment_A(seg[6]),
    .i_Segment_B(seg[5]),
    .i_Segment_C(seg[4]),
    .i_Segment_D(seg[3]),
    .i_Segment_E(seg[2]),
    .i_Segment_F(seg[1]),
    .i_Segment_G(seg[0]),
    .o_Binary_Num(binaryNum),
    .o_Valid(valid),
    .o_Invalid(invalid),
    .o_Blank(blank)
`ifdef SEG_ERR_CNT_EN
    ,
    .o_Err_Count(errCount)
`endif
  );

  always #5 clk = ~clk;

  // Glyph table for nibbles 0..F
  logic [6:0] hexPattern [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives a pattern, then watches the given number of edges (first edge is index 0)
  task automatic applyStimulus(input logic [6:0] p, input int cycles);
    seg = p;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        validCount++;
        if (firstValidEdge < 0) firstValidEdge = i;
        lastNum = binaryNum;
      end
      if (invalid) invalidCount++;
      if (valid && invalid) checkOutput("mutex", 1, 0);
    end
  endtask

  task automatic clearTally();
    validCount     = 0;
    invalidCount   = 0;
    firstValidEdge = -1;
    lastNum        = -1;
  endtask

  initial begin
    clearTally();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_num", binaryNum, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_invalid", invalid, 0);
    checkOutput("rst_blank", blank, 1);
    rstN = 1'b1;

    // Held blank after reset never pulses
    applyStimulus(7'h00, 25);
    checkOutput("blank_hold_pulses", validCount + invalidCount, 0);

    // Basic latency: 6D held, pulse at edge 18
    clearTally();
    applyStimulus(7'h6D, 25);
    checkOutput("lat_count", validCount, 1);
    checkOutput("lat_edge", firstValidEdge, 18);
    checkOutput("lat_num", binaryNum, 2);
    checkOutput("lat_blank", blank, 0);

    // Full sweep with blanks in between
    for (int h = 0; h < 16; h++) begin
      clearTally();
      applyStimulus(7'h00, 20);
      checkOutput($sformatf("sweep_blank_%0d", h), blank, 1);
      applyStimulus(hexPattern[h], 20);
      checkOutput($sformatf("sweep_cnt_%0d", h), validCount, 1);
      checkOutput($sformatf("sweep_val_%0d", h), lastNum, h);
    end

    // Short 79 then held 33
    clearTally();
    applyStimulus(7'h79, 10);
    checkOutput("short79_pulses", validCount, 0);
    applyStimulus(7'h33, 25);
    checkOutput("p33_count", validCount, 1);
    checkOutput("p33_edge", firstValidEdge, 18);
    checkOutput("p33_num", binaryNum, 4);

    // Invalid pattern leaves the nibble alone
    clearTally();
    applyStimulus(7'h01, 25);
    checkOutput("inv_count", invalidCount, 1);
    checkOutput("inv_valid", validCount, 0);
    checkOutput("inv_num", binaryNum, 4);
    checkOutput("inv_blank", blank, 0);
`ifdef SEG_ERR_CNT_EN
    checkOutput("err_one", errCount, 1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(7'h00, 20);
      applyStimulus(7'h01, 20);
    end
    checkOutput("err_sat", errCount, 255);
`endif

    // Reset in mid-window, pattern re-qualifies from scratch
    clearTally();
    applyStimulus(7'h47, 11);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_num", binaryNum, 0);
    checkOutput("mid_rst_blank", blank, 1);
    checkOutput("mid_rst_valid", valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(7'h47, 25);
    checkOutput("post_rst_count", validCount, 1);
    checkOutput("post_rst_edge", firstValidEdge, 18);
    checkOutput("post_rst_num", binaryNum, 15);
`ifdef SEG_ERR_CNT_EN
    checkOutput("post_rst_err", errCount, 0);
`endif

    // Remove and restore an accepted pattern: only one pulse
    clearTally();
    applyStimulus(7'h7E, 25);
    applyStimulus(7'h30, 5);
    applyStimulus(7'h7E, 30);
    checkOutput("restore_count", validCount, 1);
    checkOutput("restore_num", binaryNum, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
